// File: rtl/sa_matmul_core_pkg.sv
// sa_pkg: run-state encoding, sizing helpers and the saturating accumulate
// shared by sa_matmul_core and its processing elements.
package sa_pkg;

    typedef enum logic [1:0] {IDLE, STREAM, FLUSH, DONE} sa_state_e;

    localparam int SAT_W = 64;

    function automatic int k_cnt_w(input int kmax);
        return $clog2(kmax + 1);
    endfunction

    function automatic int flush_len(input int n);
        return 2 * n - 1;
    endfunction

    // Operands arrive sign/zero-extended to SAT_W; bit SAT_W of the result marks a clamp.
    function automatic logic [SAT_W:0] sat_add(input logic [SAT_W-1:0] acc,
                                               input logic [SAT_W-1:0] addend,
                                               input int aw, input bit sgn);
        logic [SAT_W-1:0] sum;
        logic [SAT_W-1:0] hi;
        logic [SAT_W-1:0] lo;
        sum = acc + addend;
        if (sgn) begin
            hi = (SAT_W'(1) << (aw - 1)) - SAT_W'(1);
            lo = ~hi;
            if ($signed(sum) > $signed(hi)) return {1'b1, hi};
            if ($signed(sum) < $signed(lo)) return {1'b1, lo};
        end else begin
            hi = (SAT_W'(1) << aw) - SAT_W'(1);
            if (sum > hi) return {1'b1, hi};
        end
        return {1'b0, sum};
    endfunction

endpackage

// File: rtl/sa_matmul_core_pe.sv
// sa_pe: one output-stationary cell; forwards a right and b down through a
// register each and accumulates a*b while the travelling tag is set.
module sa_pe
    import sa_pkg::*;
#(
    parameter int DW     = 8,
    parameter int AW     = 16,
    parameter int SIGNED = 0
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          clr,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic          tag,
    output logic [DW-1:0] a_fwd,
    output logic [DW-1:0] b_fwd,
    output logic          tag_fwd,
    output logic [AW-1:0] acc
`ifdef SA_MATMUL_SATURATE_EN
    ,
    output logic          sat_hit
`endif
);

    logic signed [2*DW-1:0] prod_s;
    logic        [2*DW-1:0] prod_u;
    logic        [AW-1:0]   addend;
    logic        [AW-1:0]   acc_next;

    assign prod_s = $signed(a) * $signed(b);
    assign prod_u = a * b;

    always_comb begin
        if (SIGNED != 0) addend = AW'(prod_s);
        else             addend = AW'(prod_u);
    end

`ifdef SA_MATMUL_SATURATE_EN
    logic [SAT_W-1:0] acc_x;
    logic [SAT_W-1:0] add_x;
    logic [SAT_W:0]   sat_sum;

    always_comb begin
        if (SIGNED != 0) begin
            acc_x = SAT_W'($signed(acc));
            add_x = SAT_W'($signed(addend));
        end else begin
            acc_x = SAT_W'(acc);
            add_x = SAT_W'(addend);
        end
    end

    assign sat_sum  = sat_add(acc_x, add_x, AW, SIGNED != 0);
    assign acc_next = sat_sum[AW-1:0];
    assign sat_hit  = tag && sat_sum[SAT_W];
`else
    assign acc_next = acc + addend;
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            a_fwd   <= '0;
            b_fwd   <= '0;
            tag_fwd <= 1'b0;
            acc     <= '0;
        end else begin
            a_fwd   <= a;
            b_fwd   <= b;
            tag_fwd <= tag;
            if (clr)      acc <= '0;
            else if (tag) acc <= acc_next;
        end
    end

endmodule

// File: rtl/sa_matmul_core.sv
// sa_matmul_core: NxN output-stationary systolic C = A*B with skewed operand feed
// and run FSM. Define SA_MATMUL_SATURATE_EN for saturating accumulators and o_sat.
module sa_matmul_core
    import sa_pkg::*;
#(
    parameter int N      = 3,
    parameter int DW     = 8,
    parameter int AW     = 16,
    parameter int KMAX   = 64,
    parameter int SIGNED = 0
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_start,
    input  logic [$clog2(KMAX+1)-1:0]  i_k_len,
    input  logic [N*DW-1:0]            i_a_vec,
    input  logic [N*DW-1:0]            i_b_vec,
    input  logic                       i_in_valid,
    output logic                       o_in_ready,
    output logic [N*N*AW-1:0]          o_c,
    output logic                       o_c_valid,
    output logic                       o_busy,
    output logic                       o_done
`ifdef SA_MATMUL_SATURATE_EN
    ,
    output logic                       o_sat
`endif
);

    localparam int KW        = k_cnt_w(KMAX);
    localparam int FLUSH_LEN = flush_len(N);
    localparam int FW        = $clog2(FLUSH_LEN);

    sa_state_e     state;
    logic [KW-1:0] k_reg;
    logic [KW-1:0] beat_cnt;
    logic [FW-1:0] flush_cnt;
    logic          start_ok;
    logic          accept;

    assign start_ok = i_start && (state == IDLE || state == DONE);
    assign accept   = i_in_valid && o_in_ready;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state      <= IDLE;
            k_reg      <= '0;
            beat_cnt   <= '0;
            flush_cnt  <= '0;
            o_in_ready <= 1'b0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_c_valid  <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (i_start) begin
                        k_reg     <= i_k_len;
                        beat_cnt  <= '0;
                        flush_cnt <= '0;
                        if (i_k_len != '0) begin
                            state      <= STREAM;
                            o_in_ready <= 1'b1;
                            o_busy     <= 1'b1;
                            o_c_valid  <= 1'b0;
                        end else begin
                            // Empty run: the cleared accumulators are the result.
                            state     <= DONE;
                            o_done    <= 1'b1;
                            o_c_valid <= 1'b1;
                        end
                    end
                end
                STREAM: begin
                    if (accept) begin
                        beat_cnt <= beat_cnt + KW'(1);
                        if (beat_cnt == k_reg - KW'(1)) begin
                            state      <= FLUSH;
                            o_in_ready <= 1'b0;
                        end
                    end
                end
                FLUSH: begin
                    flush_cnt <= flush_cnt + FW'(1);
                    if (flush_cnt == FW'(FLUSH_LEN - 1)) begin
                        state     <= DONE;
                        o_busy    <= 1'b0;
                        o_done    <= 1'b1;
                        o_c_valid <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic [DW-1:0]             a_h [N][N+1];
    logic                      tag_h [N][N+1];
    logic [DW-1:0]             b_v [N+1][N];
    logic [N*(2*DW+1)-1:0]     unused_edges;
`ifdef SA_MATMUL_SATURATE_EN
    logic [N*N-1:0]            sat_hits;
`endif

    // Stage 0 captures the beat (zeros and tag=0 on bubbles); row/col i adds i more stages.
    for (genvar i = 0; i < N; i++) begin : g_skew
        logic [DW-1:0] a_dly [i+1];
        logic [DW-1:0] b_dly [i+1];
        logic          vld_dly [i+1];

        always_ff @(posedge i_clk) begin
            if (!i_rst_n) begin
                for (int d = 0; d <= i; d++) begin
                    a_dly[d]   <= '0;
                    b_dly[d]   <= '0;
                    vld_dly[d] <= 1'b0;
                end
            end else begin
                a_dly[0]   <= accept ? i_a_vec[i*DW +: DW] : '0;
                b_dly[0]   <= accept ? i_b_vec[i*DW +: DW] : '0;
                vld_dly[0] <= accept;
                for (int d = 1; d <= i; d++) begin
                    a_dly[d]   <= a_dly[d-1];
                    b_dly[d]   <= b_dly[d-1];
                    vld_dly[d] <= vld_dly[d-1];
                end
            end
        end

        assign a_h[i][0]   = a_dly[i];
        assign tag_h[i][0] = vld_dly[i];
        assign b_v[0][i]   = b_dly[i];
        assign unused_edges[i*(2*DW+1) +: 2*DW+1] = {a_h[i][N], b_v[N][i], tag_h[i][N]};
    end

    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            sa_pe #(
                .DW     (DW),
                .AW     (AW),
                .SIGNED (SIGNED)
            ) u_pe (
                .i_clk   (i_clk),
                .i_rst_n (i_rst_n),
                .clr     (start_ok),
                .a       (a_h[i][j]),
                .b       (b_v[i][j]),
                .tag     (tag_h[i][j]),
                .a_fwd   (a_h[i][j+1]),
                .b_fwd   (b_v[i+1][j]),
                .tag_fwd (tag_h[i][j+1]),
                .acc     (o_c[(i*N+j)*AW +: AW])
`ifdef SA_MATMUL_SATURATE_EN
                ,
                .sat_hit (sat_hits[i*N+j])
`endif
            );
        end
    end

`ifdef SA_MATMUL_SATURATE_EN
    always_ff @(posedge i_clk) begin
        if (!i_rst_n)        o_sat <= 1'b0;
        else if (start_ok)   o_sat <= 1'b0;
        else if (|sat_hits)  o_sat <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_sa_matmul_core.sv
// tb_sa_matmul_core: drives an unsigned and a signed instance with identical
// stimulus and checks each result against a plain-arithmetic matrix model.
module tb_sa_matmul_core;

    localparam int N   = 3;
    localparam int DW  = 8;
    localparam int AW  = 16;
    localparam int KMAX = 64;
    localparam int KLW = $clog2(KMAX + 1);
    localparam int CW  = N * N * AW;
    localparam int VW  = N * DW;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           start;
    logic [KLW-1:0] k_len;
    logic [VW-1:0]  a_vec;
    logic [VW-1:0]  b_vec;
    logic           in_valid;

    logic rdy_u, cv_u, busy_u, done_u;
    logic rdy_s, cv_s, busy_s, done_s;
    logic [CW-1:0] c_u, c_s;
`ifdef SA_MATMUL_SATURATE_EN
    logic sat_u, sat_s;
`endif

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    sa_matmul_core #(.N(N), .DW(DW), .AW(AW), .KMAX(KMAX), .SIGNED(0)) u_dut_u (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_k_len(k_len),
        .i_a_vec(a_vec), .i_b_vec(b_vec), .i_in_valid(in_valid),
        .o_in_ready(rdy_u), .o_c(c_u), .o_c_valid(cv_u), .o_busy(busy_u), .o_done(done_u)
`ifdef SA_MATMUL_SATURATE_EN
        , .o_sat(sat_u)
`endif
    );

    sa_matmul_core #(.N(N), .DW(DW), .AW(AW), .KMAX(KMAX), .SIGNED(1)) u_dut_s (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_k_len(k_len),
        .i_a_vec(a_vec), .i_b_vec(b_vec), .i_in_valid(in_valid),
        .o_in_ready(rdy_s), .o_c(c_s), .o_c_valid(cv_s), .o_busy(busy_s), .o_done(done_s)
`ifdef SA_MATMUL_SATURATE_EN
        , .o_sat(sat_s)
`endif
    );

    typedef struct {
        logic [CW-1:0] cu;
        logic [CW-1:0] cs;
        bit            satu;
        bit            sats;
        int            ref_cyc;
        int            lat;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [DW-1:0] a_m [KMAX][N];
    logic [DW-1:0] b_m [KMAX][N];

    task automatic check(input string nm, input logic [CW-1:0] act, input logic [CW-1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // C[i][j] = sum_k A[i][k]*B[k][j], reduced to AW bits (or clamped per add when saturating).
    function automatic logic [CW-1:0] model(input int k, input bit sgn, output bit sat);
        logic [CW-1:0] r;
        longint acc, x, y;
`ifdef SA_MATMUL_SATURATE_EN
        longint hi, lo;
        hi = sgn ? (longint'(1) << (AW - 1)) - 1 : (longint'(1) << AW) - 1;
        lo = sgn ? -(longint'(1) << (AW - 1)) : 0;
`endif
        r = '0;
        sat = 1'b0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                acc = 0;
                for (int kk = 0; kk < k; kk++) begin
                    x = sgn ? longint'($signed(a_m[kk][i])) : longint'(a_m[kk][i]);
                    y = sgn ? longint'($signed(b_m[kk][j])) : longint'(b_m[kk][j]);
                    acc = acc + x * y;
`ifdef SA_MATMUL_SATURATE_EN
                    if (acc > hi) begin acc = hi; sat = 1'b1; end
                    else if (acc < lo) begin acc = lo; sat = 1'b1; end
`endif
                end
                r[(i*N+j)*AW +: AW] = acc[AW-1:0];
            end
        end
        return r;
    endfunction

    task automatic push_exp(input int k, input int ref_c, input int lat);
        exp_t e;
        bit   su, ss;
        e.cu = model(k, 1'b0, su);
        e.cs = model(k, 1'b1, ss);
        e.satu = su;
        e.sats = ss;
        e.ref_cyc = ref_c;
        e.lat = lat;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (rst_n && (done_u || done_s)) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: got done at cycle %0d, expected no result pending", cyc);
            end else begin
                mon_e = exp_q.pop_front();
                check("done_u", CW'(done_u), CW'(1));
                check("done_s", CW'(done_s), CW'(1));
                check("done_latency", CW'(cyc - mon_e.ref_cyc), CW'(mon_e.lat));
                check("c_unsigned", c_u, mon_e.cu);
                check("c_signed", c_s, mon_e.cs);
                check("c_valid_u", CW'(cv_u), CW'(1));
                check("c_valid_s", CW'(cv_s), CW'(1));
                check("busy_at_done", CW'(busy_u), CW'(0));
`ifdef SA_MATMUL_SATURATE_EN
                check("sat_u", CW'(sat_u), CW'(mon_e.satu));
                check("sat_s", CW'(sat_s), CW'(mon_e.sats));
`endif
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_rand(input int k);
        for (int kk = 0; kk < k; kk++) begin
            for (int i = 0; i < N; i++) begin
                a_m[kk][i] = DW'($urandom);
                b_m[kk][i] = DW'($urandom);
            end
        end
    endtask

    task automatic start_run(input int k);
        start = 1'b1;
        k_len = KLW'(k);
        tick();
        start = 1'b0;
    endtask

    task automatic feed(input int k, input int bub_mask, input bit noise, output int last);
        last = cyc;
        for (int kk = 0; kk < k; kk++) begin
            for (int i = 0; i < N; i++) begin
                a_vec[i*DW +: DW] = a_m[kk][i];
                b_vec[i*DW +: DW] = b_m[kk][i];
            end
            in_valid = 1'b1;
            if (noise) begin
                start = 1'($urandom_range(0, 1));
                k_len = KLW'($urandom_range(0, 10));
            end
            check("in_ready_stream", CW'(rdy_u), CW'(1));
            check("busy_stream", CW'(busy_s), CW'(1));
            last = cyc;
            tick();
            start = 1'b0;
            if (bub_mask[kk % 32]) begin
                in_valid = 1'b0;
                a_vec = VW'($urandom);
                b_vec = VW'($urandom);
                tick();
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (done_u !== 1'b1 && t < 64) begin
            tick();
            t++;
        end
        n_cmp++;
        if (t >= 64) begin
            n_bad++;
            $display("FAIL done_timeout: got no done after %0d cycles, expected done", t);
        end
    endtask

    task automatic do_run(input int k, input int bub, input bit noise);
        int last;
        start_run(k);
        feed(k, bub, noise, last);
        push_exp(k, last, 2 * N);
        wait_done();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running at cycle %0d, expected finish", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [CW-1:0] held;
        bit            dummy;
        int            last;

        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; k_len = '0; a_vec = '0; b_vec = '0;
        repeat (3) tick();
        check("rst_c", c_u, '0);
        check("rst_c_s", c_s, '0);
        check("rst_c_valid", CW'(cv_u), CW'(0));
        check("rst_busy", CW'(busy_u), CW'(0));
        check("rst_done", CW'(done_u), CW'(0));
        check("rst_in_ready", CW'(rdy_u), CW'(0));
`ifdef SA_MATMUL_SATURATE_EN
        check("rst_sat", CW'(sat_u), CW'(0));
`endif
        rst_n = 1'b1;
        tick();

        // Identity A, B = 1..9: C must equal B and stay put.
        for (int kk = 0; kk < 3; kk++) begin
            for (int i = 0; i < 3; i++) begin
                a_m[kk][i] = (i == kk) ? 8'd1 : 8'd0;
                b_m[kk][i] = DW'(kk * 3 + i + 1);
            end
        end
        do_run(3, 0, 1'b0);
        held = '0;
        for (int i = 0; i < 9; i++) held[i*AW +: AW] = AW'(i + 1);
        repeat (3) tick();
        check("identity_hold", c_u, held);
        check("identity_valid_hold", CW'(cv_u), CW'(1));

        // All 255 with bubbles after beats 1 and 3.
        for (int kk = 0; kk < 4; kk++)
            for (int i = 0; i < N; i++) begin a_m[kk][i] = 8'hFF; b_m[kk][i] = 8'hFF; end
        do_run(4, 32'b0101, 1'b0);

        // -3 * 5 over K=2.
        for (int kk = 0; kk < 2; kk++)
            for (int i = 0; i < N; i++) begin a_m[kk][i] = 8'hFD; b_m[kk][i] = 8'd5; end
        do_run(2, 0, 1'b0);

        // Empty run: done next cycle, zero result, no beats taken.
        push_exp(0, cyc, 1);
        start_run(0);
        for (int t = 0; t < 3; t++) begin
            in_valid = 1'b1;
            a_vec = VW'($urandom);
            b_vec = VW'($urandom);
            check("k0_in_ready", CW'(rdy_u), CW'(0));
            tick();
        end
        in_valid = 1'b0;
        check("k0_c_zero", c_u, '0);
        check("k0_c_valid", CW'(cv_u), CW'(1));

        // Reset after the second beat of a K=3 run aborts it silently.
        fill_rand(3);
        start_run(3);
        feed(2, 0, 1'b0, last);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("abort_c", c_u, '0);
        check("abort_c_valid", CW'(cv_u), CW'(0));
        check("abort_busy", CW'(busy_u), CW'(0));
        check("abort_in_ready", CW'(rdy_u), CW'(0));
        check("abort_done", CW'(done_s), CW'(0));
        repeat (12) tick();
        fill_rand(3);
        do_run(3, 0, 1'b0);

        // Back-to-back: restart in the done cycle.
        fill_rand(3);
        start_run(3);
        feed(3, 0, 1'b0, last);
        push_exp(3, last, 2 * N);
        wait_done();
        fill_rand(3);
        start_run(3);
        check("b2b_c_valid_drop", CW'(cv_u), CW'(0));
        check("b2b_acc_cleared", c_u, '0);
        feed(3, 0, 1'b0, last);
        push_exp(3, last, 2 * N);
        wait_done();

        // Random runs with bubbles and ignored start pulses mid-stream.
        for (int r = 0; r < 12; r++) begin
            int k;
            k = $urandom_range(1, 12);
            fill_rand(k);
            do_run(k, int'($urandom), 1'b1);
        end

        repeat (4) tick();
        check("scoreboard_drained", CW'(exp_q.size()), CW'(0));
        dummy = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + int'(dummy));
        $finish;
    end

endmodule
